// File: rtl/cada_mem_bank_array.sv
// rtl/cada_mem_bank_array.sv - banked dual-port SRAM test wrapper with output crossbar
//
// Purpose:
//   NB dual-port SRAM banks of 2**AW x DW words. Each bank port is driven by its
//   own start/count/stride address generator. An NO-lane crossbar selects bank
//   read registers onto dataOut. A small interface memory (I-memory) with its own
//   two generators provides the scalar tap oi.
//
// Ports:
//   clk, rst                         single clock, synchronous active-high reset
//   addrIn1/2, count1/2, strideIn1/2,
//   writeEnIn1/2, validIn1/2         per-bank generator commands (bank b at [b*W+:W])
//   dataIn                           per-bank write data, port1 low word, port2 high word
//   IOConfig                         {mOutConfig, gcontrol}: lane routing, lane blank
//                                    mask, bank write enables
//   dataOut, IglobalDataOut          NO x DW lane outputs (identical)
//   Iaddr*/Icount*/Istride*/
//   IwriteEn*/Ivalid*, IglobalDataIn I-memory generator commands and write data
//   o0..o7                           port-2 read registers of banks 0..7
//   oi                               I-memory port-2 read register
//
// Build option:
//   CADA_OUT_REG_EN  register dataOut/IglobalDataOut (read-to-lane latency 2)

module cada_addr_gen #(
    parameter int AW = 6,
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addrIn,
    input  logic [CW-1:0] countIn,
    input  logic          strideIn,
    input  logic          writeEnIn,
    input  logic          validIn,
    output logic          accEn,
    output logic [AW-1:0] accAddr,
    output logic          accWrite
);
    logic          busy;
    logic [AW-1:0] nextAddr;
    logic [CW-1:0] left;
    logic          stride;
    logic          we;

    // A command is serviced in the cycle it arrives, so the access port is
    // driven straight from the inputs when validIn is high.
    always_comb begin
        accEn    = 1'b0;
        accAddr  = nextAddr;
        accWrite = we;
        if (!rst) begin
            if (validIn) begin
                accEn    = (countIn != '0);
                accAddr  = addrIn;
                accWrite = writeEnIn;
            end else begin
                accEn = busy;
            end
        end
    end

    // left counts accesses still owed after the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            nextAddr <= '0;
            left     <= '0;
            stride   <= 1'b0;
            we       <= 1'b0;
        end else if (validIn) begin
            busy     <= (countIn > CW'(1));
            nextAddr <= addrIn + {{(AW-1){1'b0}}, strideIn};
            left     <= countIn - CW'(1);
            stride   <= strideIn;
            we       <= writeEnIn;
        end else if (busy) begin
            busy     <= (left > CW'(1));
            nextAddr <= nextAddr + {{(AW-1){1'b0}}, stride};
            left     <= left - CW'(1);
        end
    end
endmodule

module cada_mem_bank_array #(
    parameter int NB  = 108,
    parameter int AW  = 6,
    parameter int CW  = 7,
    parameter int DW  = 16,
    parameter int NO  = 18,
    parameter int LCW = 24,
    parameter int IAW = 5,
    parameter int ICW = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NB*AW-1:0]         addrIn1,
    input  logic [NB*AW-1:0]         addrIn2,
    input  logic [NB*CW-1:0]         count1,
    input  logic [NB*CW-1:0]         count2,
    input  logic [NB-1:0]            strideIn1,
    input  logic [NB-1:0]            strideIn2,
    input  logic [NB-1:0]            writeEnIn1,
    input  logic [NB-1:0]            writeEnIn2,
    input  logic [NB-1:0]            validIn1,
    input  logic [NB-1:0]            validIn2,
    input  logic [NO*LCW+NB+NO-1:0]  IOConfig,
    input  logic [NB*2*DW-1:0]       dataIn,
    output logic [NO*DW-1:0]         dataOut,
    input  logic [NB*2*DW-1:0]       IglobalDataIn,
    output logic [NO*DW-1:0]         IglobalDataOut,
    input  logic [IAW-1:0]           IaddrIn1,
    input  logic [IAW-1:0]           IaddrIn2,
    input  logic                     IstrideIn1,
    input  logic                     IstrideIn2,
    input  logic                     IwriteEnIn1,
    input  logic                     IwriteEnIn2,
    input  logic                     IvalidIn1,
    input  logic                     IvalidIn2,
    input  logic [ICW-1:0]           Icount1,
    input  logic [ICW-1:0]           Icount2,
    output logic [DW-1:0]            o0,
    output logic [DW-1:0]            o1,
    output logic [DW-1:0]            o2,
    output logic [DW-1:0]            o3,
    output logic [DW-1:0]            o4,
    output logic [DW-1:0]            o5,
    output logic [DW-1:0]            o6,
    output logic [DW-1:0]            o7,
    output logic [DW-1:0]            oi
);
    localparam int CFGW = NO*LCW + NB + NO;
    localparam logic [6:0] BANK_LIMIT = 7'(NB);

    logic [NB+NO-1:0]         gcontrol;
    logic [NO*LCW-1:0]        mOutConfig;
    logic [NB-1:0][DW-1:0]    rdBus1;
    logic [NB-1:0][DW-1:0]    rdBus2;
    logic [NO-1:0][DW-1:0]    laneData;
    logic [NB*2*DW-DW-1:0]    unusedIglobal;

    assign gcontrol      = IOConfig[NB+NO-1:0];
    assign mOutConfig    = IOConfig[CFGW-1:NB+NO];
    assign unusedIglobal = IglobalDataIn[NB*2*DW-1:DW];

    for (genvar b = 0; b < NB; b++) begin : gBank
        logic          en1, en2, wr1, wr2;
        logic [AW-1:0] ad1, ad2;
        logic [DW-1:0] rd1, rd2;
        logic [DW-1:0] mem [2**AW];

        cada_addr_gen #(.AW(AW), .CW(CW)) uGen1 (
            .clk(clk), .rst(rst),
            .addrIn(addrIn1[b*AW+:AW]), .countIn(count1[b*CW+:CW]),
            .strideIn(strideIn1[b]), .writeEnIn(writeEnIn1[b]), .validIn(validIn1[b]),
            .accEn(en1), .accAddr(ad1), .accWrite(wr1)
        );
        cada_addr_gen #(.AW(AW), .CW(CW)) uGen2 (
            .clk(clk), .rst(rst),
            .addrIn(addrIn2[b*AW+:AW]), .countIn(count2[b*CW+:CW]),
            .strideIn(strideIn2[b]), .writeEnIn(writeEnIn2[b]), .validIn(validIn2[b]),
            .accEn(en2), .accAddr(ad2), .accWrite(wr2)
        );

        // Port 2 is written last so it wins a same-address collision. A
        // disabled bank drops the write while its generator keeps stepping.
        always_ff @(posedge clk) begin
            if (en1 && wr1 && gcontrol[b]) mem[ad1] <= dataIn[b*2*DW+:DW];
            if (en2 && wr2 && gcontrol[b]) mem[ad2] <= dataIn[b*2*DW+DW+:DW];
        end

        // Nonblocking reads sample the pre-write contents (read-before-write).
        always_ff @(posedge clk) begin
            if (rst) begin
                rd1 <= '0;
                rd2 <= '0;
            end else begin
                if (en1 && !wr1) rd1 <= mem[ad1];
                if (en2 && !wr2) rd2 <= mem[ad2];
            end
        end

        assign rdBus1[b] = rd1;
        assign rdBus2[b] = rd2;
    end

    for (genvar j = 0; j < NO; j++) begin : gLane
        logic [LCW-1:0]   cfg;
        logic [6:0]       bankSel;
        logic             usePort2;
        logic [LCW-9:0]   unusedCfg;

        assign cfg       = mOutConfig[j*LCW+:LCW];
        assign bankSel   = cfg[6:0];
        assign usePort2  = cfg[7];
        assign unusedCfg = cfg[LCW-1:8];

        assign laneData[j] = (gcontrol[NB+j] || (bankSel >= BANK_LIMIT)) ? '0 :
                             (usePort2 ? rdBus2[bankSel] : rdBus1[bankSel]);
    end

`ifdef CADA_OUT_REG_EN
    logic [NO*DW-1:0] laneReg;
    always_ff @(posedge clk) begin
        if (rst) laneReg <= '0;
        else     laneReg <= laneData;
    end
    assign dataOut = laneReg;
`else
    assign dataOut = laneData;
`endif
    assign IglobalDataOut = dataOut;

    assign o0 = rdBus2[0];
    assign o1 = rdBus2[1];
    assign o2 = rdBus2[2];
    assign o3 = rdBus2[3];
    assign o4 = rdBus2[4];
    assign o5 = rdBus2[5];
    assign o6 = rdBus2[6];
    assign o7 = rdBus2[7];

    // I-memory: no bank-enable gating; only the port-2 read register is visible.
    logic           ien1, ien2, iwr1, iwr2;
    logic [IAW-1:0] iad1, iad2;
    logic [DW-1:0]  iRd2;
    logic [DW-1:0]  iMem [2**IAW];

    cada_addr_gen #(.AW(IAW), .CW(ICW)) uIGen1 (
        .clk(clk), .rst(rst),
        .addrIn(IaddrIn1), .countIn(Icount1), .strideIn(IstrideIn1),
        .writeEnIn(IwriteEnIn1), .validIn(IvalidIn1),
        .accEn(ien1), .accAddr(iad1), .accWrite(iwr1)
    );
    cada_addr_gen #(.AW(IAW), .CW(ICW)) uIGen2 (
        .clk(clk), .rst(rst),
        .addrIn(IaddrIn2), .countIn(Icount2), .strideIn(IstrideIn2),
        .writeEnIn(IwriteEnIn2), .validIn(IvalidIn2),
        .accEn(ien2), .accAddr(iad2), .accWrite(iwr2)
    );

    always_ff @(posedge clk) begin
        if (ien1 && iwr1) iMem[iad1] <= IglobalDataIn[DW-1:0];
        if (ien2 && iwr2) iMem[iad2] <= IglobalDataIn[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst)                iRd2 <= '0;
        else if (ien2 && !iwr2) iRd2 <= iMem[iad2];
    end

    assign oi = iRd2;
endmodule

// File: tb/tb_cada_mem_bank_array.sv
// tb/tb_cada_mem_bank_array.sv - randomized model-checked bench for cada_mem_bank_array
module tb_cada_mem_bank_array;
    localparam int NB  = 108;
    localparam int AW  = 6;
    localparam int CW  = 7;
    localparam int DW  = 16;
    localparam int NO  = 18;
    localparam int LCW = 24;
    localparam int IAW = 5;
    localparam int ICW = 8;
    localparam int WB  = NO*DW;

    logic clk;
    logic rst;
    logic [NB*AW-1:0]        addrIn1, addrIn2;
    logic [NB*CW-1:0]        count1, count2;
    logic [NB-1:0]           strideIn1, strideIn2, writeEnIn1, writeEnIn2, validIn1, validIn2;
    logic [NO*LCW+NB+NO-1:0] IOConfig;
    logic [NB*2*DW-1:0]      dataIn, IglobalDataIn;
    logic [NO*DW-1:0]        dataOut, IglobalDataOut;
    logic [IAW-1:0]          IaddrIn1, IaddrIn2;
    logic                    IstrideIn1, IstrideIn2, IwriteEnIn1, IwriteEnIn2, IvalidIn1, IvalidIn2;
    logic [ICW-1:0]          Icount1, Icount2;
    logic [DW-1:0]           o0, o1, o2, o3, o4, o5, o6, o7, oi;

    cada_mem_bank_array dut (
        .clk(clk), .rst(rst),
        .addrIn1(addrIn1), .addrIn2(addrIn2), .count1(count1), .count2(count2),
        .strideIn1(strideIn1), .strideIn2(strideIn2),
        .writeEnIn1(writeEnIn1), .writeEnIn2(writeEnIn2),
        .validIn1(validIn1), .validIn2(validIn2),
        .IOConfig(IOConfig), .dataIn(dataIn), .dataOut(dataOut),
        .IglobalDataIn(IglobalDataIn), .IglobalDataOut(IglobalDataOut),
        .IaddrIn1(IaddrIn1), .IaddrIn2(IaddrIn2),
        .IstrideIn1(IstrideIn1), .IstrideIn2(IstrideIn2),
        .IwriteEnIn1(IwriteEnIn1), .IwriteEnIn2(IwriteEnIn2),
        .IvalidIn1(IvalidIn1), .IvalidIn2(IvalidIn2),
        .Icount1(Icount1), .Icount2(Icount2),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7), .oi(oi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus state, packed onto the DUT buses below.
    logic [AW-1:0]  tA1 [NB], tA2 [NB];
    logic [CW-1:0]  tC1 [NB], tC2 [NB];
    logic           tS1 [NB], tS2 [NB], tW1 [NB], tW2 [NB], tV1 [NB], tV2 [NB];
    logic [DW-1:0]  tD1 [NB], tD2 [NB];
    logic           tG [NB];
    logic           tBlank [NO];
    logic [LCW-1:0] tCfg [NO];
    logic [DW-1:0]  tIData;

    always_comb begin
        addrIn1 = '0; addrIn2 = '0; count1 = '0; count2 = '0;
        strideIn1 = '0; strideIn2 = '0; writeEnIn1 = '0; writeEnIn2 = '0;
        validIn1 = '0; validIn2 = '0; dataIn = '0; IOConfig = '0;
        for (int b = 0; b < NB; b++) begin
            addrIn1[b*AW+:AW] = tA1[b];
            addrIn2[b*AW+:AW] = tA2[b];
            count1[b*CW+:CW]  = tC1[b];
            count2[b*CW+:CW]  = tC2[b];
            strideIn1[b] = tS1[b];  strideIn2[b] = tS2[b];
            writeEnIn1[b] = tW1[b]; writeEnIn2[b] = tW2[b];
            validIn1[b] = tV1[b];   validIn2[b] = tV2[b];
            dataIn[b*2*DW+:DW]    = tD1[b];
            dataIn[b*2*DW+DW+:DW] = tD2[b];
            IOConfig[b] = tG[b];
        end
        for (int j = 0; j < NO; j++) begin
            IOConfig[NB+j] = tBlank[j];
            IOConfig[NB+NO+j*LCW+:LCW] = tCfg[j];
        end
    end
    assign IglobalDataIn = {{(NB*2*DW-DW){1'b1}}, tIData};

    // Reference model: a command is a list of accesses start + i*stride.
    typedef struct {
        int start;
        int cnt;
        int idx;
        int stride;
        bit we;
    } gen_t;

    gen_t          g1 [NB], g2 [NB], ig1, ig2;
    logic [DW-1:0] mMem [NB][64];
    logic [DW-1:0] mR1 [NB], mR2 [NB];
    logic [DW-1:0] iMem [32];
    logic [DW-1:0] mOi;
    logic [WB-1:0] expLane;

    int nChecks = 0;
    int nFail   = 0;

    task automatic checkVal(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic genStep(inout gen_t g, input bit v, input int a, input int c, input bit s,
                           input bit w, input int modv, output int acc);
        if (v) begin
            g.start = a; g.cnt = c; g.idx = 0; g.stride = int'(s); g.we = w;
        end
        acc = -1;
        if (g.idx < g.cnt) begin
            acc = (g.start + g.idx * g.stride) % modv;
            g.idx++;
        end
    endtask

    function automatic logic [WB-1:0] laneModel();
        logic [WB-1:0] r;
        int idx;
        r = '0;
        for (int j = 0; j < NO; j++) begin
            idx = int'(tCfg[j][6:0]);
            if (!tBlank[j] && idx < NB) r[j*DW+:DW] = tCfg[j][7] ? mR2[idx] : mR1[idx];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] initPat(input int b, input int a);
        return 16'(b * 131 + a * 7 + 'h1234);
    endfunction

    task automatic clearValids();
        for (int b = 0; b < NB; b++) begin
            tV1[b] = 1'b0; tV2[b] = 1'b0;
        end
        IvalidIn1 = 1'b0; IvalidIn2 = 1'b0;
    endtask

    task automatic cmd(input int port, input int b, input int a, input int c, input bit s, input bit w);
        if (port == 1) begin
            tV1[b] = 1'b1; tA1[b] = 6'(a); tC1[b] = 7'(c); tS1[b] = s; tW1[b] = w;
        end else begin
            tV2[b] = 1'b1; tA2[b] = 6'(a); tC2[b] = 7'(c); tS2[b] = s; tW2[b] = w;
        end
    endtask

    task automatic icmd(input int port, input int a, input int c, input bit s, input bit w);
        if (port == 1) begin
            IvalidIn1 = 1'b1; IaddrIn1 = 5'(a); Icount1 = 8'(c); IstrideIn1 = s; IwriteEnIn1 = w;
        end else begin
            IvalidIn2 = 1'b1; IaddrIn2 = 5'(a); Icount2 = 8'(c); IstrideIn2 = s; IwriteEnIn2 = w;
        end
    endtask

    // Advance the model over one clock edge, clock the DUT, compare all outputs.
    task automatic tick();
        int a1, a2;
`ifdef CADA_OUT_REG_EN
        logic [WB-1:0] pre;
        pre = rst ? '0 : laneModel();
`endif
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                g1[b].cnt = 0; g1[b].idx = 0; g2[b].cnt = 0; g2[b].idx = 0;
                mR1[b] = '0; mR2[b] = '0;
            end
            ig1.cnt = 0; ig1.idx = 0; ig2.cnt = 0; ig2.idx = 0;
            mOi = '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                genStep(g1[b], tV1[b], int'(tA1[b]), int'(tC1[b]), tS1[b], tW1[b], 64, a1);
                genStep(g2[b], tV2[b], int'(tA2[b]), int'(tC2[b]), tS2[b], tW2[b], 64, a2);
                if (a1 >= 0 && !g1[b].we) mR1[b] = mMem[b][a1];
                if (a2 >= 0 && !g2[b].we) mR2[b] = mMem[b][a2];
                if (tG[b]) begin
                    if (a1 >= 0 && g1[b].we) mMem[b][a1] = tD1[b];
                    if (a2 >= 0 && g2[b].we) mMem[b][a2] = tD2[b];
                end
            end
            genStep(ig1, IvalidIn1, int'(IaddrIn1), int'(Icount1), IstrideIn1, IwriteEnIn1, 32, a1);
            genStep(ig2, IvalidIn2, int'(IaddrIn2), int'(Icount2), IstrideIn2, IwriteEnIn2, 32, a2);
            if (a2 >= 0 && !ig2.we) mOi = iMem[a2];
            if (a1 >= 0 && ig1.we) iMem[a1] = tIData;
            if (a2 >= 0 && ig2.we) iMem[a2] = tIData;
        end
        @(posedge clk);
        #1;
`ifdef CADA_OUT_REG_EN
        expLane = pre;
`else
        expLane = laneModel();
`endif
        checkVal("taps", {o7, o6, o5, o4, o3, o2, o1, o0},
                 {mR2[7], mR2[6], mR2[5], mR2[4], mR2[3], mR2[2], mR2[1], mR2[0]});
        checkVal("oi", oi, mOi);
        checkVal("dataOut", dataOut, expLane);
        checkVal("IglobalDataOut", IglobalDataOut, expLane);
        clearValids();
    endtask

    initial begin
        for (int b = 0; b < NB; b++) begin
            tA1[b] = '0; tA2[b] = '0; tC1[b] = '0; tC2[b] = '0;
            tS1[b] = 1'b0; tS2[b] = 1'b0; tW1[b] = 1'b0; tW2[b] = 1'b0;
            tD1[b] = '0; tD2[b] = '0; tG[b] = 1'b1;
            g1[b] = '{0, 0, 0, 0, 1'b0}; g2[b] = '{0, 0, 0, 0, 1'b0};
            mR1[b] = '0; mR2[b] = '0;
        end
        for (int j = 0; j < NO; j++) begin
            tBlank[j] = 1'b0; tCfg[j] = '0;
        end
        ig1 = '{0, 0, 0, 0, 1'b0}; ig2 = '{0, 0, 0, 0, 1'b0};
        mOi = '0; tIData = '0;
        IaddrIn1 = '0; IaddrIn2 = '0; Icount1 = '0; Icount2 = '0;
        IstrideIn1 = 1'b0; IstrideIn2 = 1'b0; IwriteEnIn1 = 1'b0; IwriteEnIn2 = 1'b0;
        clearValids();

        // Reset hold with commands asserted; they must be ignored.
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            for (int b = 0; b < 8; b++) cmd(2, b, $urandom_range(0, 63), $urandom_range(1, 20), 1'b1, 1'b0);
            icmd(2, $urandom_range(0, 31), 5, 1'b1, 1'b0);
            tick();
        end
        checkVal("rstDataOut", dataOut, '0);
        checkVal("rstOi", oi, '0);
        checkVal("rstO0", o0, '0);
        rst = 1'b0;

        // Fill every bank and the I-memory with known data.
        for (int b = 0; b < NB; b++) cmd(1, b, 0, 64, 1'b1, 1'b1);
        icmd(1, 0, 32, 1'b1, 1'b1);
        for (int k = 0; k < 64; k++) begin
            for (int b = 0; b < NB; b++) tD1[b] = initPat(b, k);
            tIData = 16'('h5000 + k);
            tick();
        end
        checkVal("idleAfterRst", o0, '0);

        // Sequential write then read on bank 0.
        cmd(1, 0, 0, 3, 1'b1, 1'b1);
        tD1[0] = 16'd1; tick();
        tD1[0] = 16'd2; tick();
        tD1[0] = 16'd3; tick();
        cmd(2, 0, 0, 3, 1'b1, 1'b0);
        tick(); checkVal("seqRd0", o0, 16'd1);
        tick(); checkVal("seqRd1", o0, 16'd2);
        tick(); checkVal("seqRd2", o0, 16'd3);
        tick(); checkVal("seqHold", o0, 16'd3);

        // Stride 0 keeps hitting one address; the last write survives.
        cmd(1, 0, 4, 3, 1'b0, 1'b1);
        tD1[0] = 16'd5; tick();
        tD1[0] = 16'd6; tick();
        tD1[0] = 16'd7; tick();
        cmd(2, 0, 4, 1, 1'b1, 1'b0);
        tick(); checkVal("stride0", o0, 16'd7);

        // Disabled bank drops writes.
        tG[20] = 1'b0;
        tCfg[1] = {16'h0, 1'b1, 7'd20};
        cmd(1, 20, 7, 1, 1'b1, 1'b1);
        tD1[20] = 16'hBEEF; tick();
        cmd(2, 20, 7, 1, 1'b1, 1'b0);
        tick(); tick();
        checkVal("disabledBank", dataOut[31:16], initPat(20, 7));
        tG[20] = 1'b1;

        // Lane routing, blanking and out-of-range bank index.
        tCfg[0] = {16'h0, 1'b1, 7'd0};
        tick(); tick();
        checkVal("lane0Port2", dataOut[15:0], 16'd7);
        tBlank[0] = 1'b1;
        tick(); tick();
        checkVal("lane0Blank", dataOut[15:0], 16'd0);
        tBlank[0] = 1'b0;
        tCfg[0] = {16'h0, 1'b1, 7'd120};
        tick(); tick();
        checkVal("lane0Idx120", dataOut[15:0], 16'd0);
        tCfg[0] = {16'h0, 1'b1, 7'd0};

        // Address wrap 62,63,0,1 and mid-burst restart.
        cmd(1, 0, 62, 4, 1'b1, 1'b1);
        tD1[0] = 16'h11; tick();
        tD1[0] = 16'h22; tick();
        tD1[0] = 16'h33; tick();
        tD1[0] = 16'h44; tick();
        cmd(2, 0, 62, 4, 1'b1, 1'b0);
        tick(); checkVal("wrap62", o0, 16'h11);
        tick(); checkVal("wrap63", o0, 16'h22);
        cmd(2, 0, 4, 1, 1'b1, 1'b0);
        tick(); checkVal("restart", o0, 16'd7);
        tick(); checkVal("restartHold", o0, 16'd7);
        cmd(2, 0, 0, 2, 1'b1, 1'b0);
        tick(); checkVal("wrap0", o0, 16'h33);
        tick(); checkVal("wrap1", o0, 16'h44);

        // I-memory wrap 31 -> 0.
        icmd(1, 31, 2, 1'b1, 1'b1);
        tIData = 16'd9;  tick();
        tIData = 16'd10; tick();
        icmd(2, 31, 2, 1'b1, 1'b0);
        tick(); checkVal("imemRd0", oi, 16'd9);
        tick(); checkVal("imemRd1", oi, 16'd10);

        // Read-to-lane latency on lane 0 (bank 0 port 2).
        cmd(1, 0, 10, 1, 1'b1, 1'b1);
        tD1[0] = 16'hABCD; tick();
        tick();
        cmd(2, 0, 10, 1, 1'b1, 0);
        tick();
        checkVal("latTap", o0, 16'hABCD);
`ifdef CADA_OUT_REG_EN
        checkVal("latLane1", dataOut[15:0], 16'h0044);
`else
        checkVal("latLane1", dataOut[15:0], 16'hABCD);
`endif
        tick();
        checkVal("latLane2", dataOut[15:0], 16'hABCD);

        // Randomized traffic, occasional resets and config changes.
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int b = 0; b < NB; b++) begin
                tD1[b] = 16'($urandom);
                tD2[b] = 16'($urandom);
                if ($urandom_range(0, (b < 8) ? 3 : 15) == 0)
                    cmd(1, b, $urandom_range(0, 63), $urandom_range(0, 70), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, (b < 8) ? 3 : 15) == 0)
                    cmd(2, b, $urandom_range(0, 63), $urandom_range(0, 70), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 31) == 0) begin
                int gb;
                gb = $urandom_range(0, NB-1);
                tG[gb] = ~tG[gb];
            end
            if ($urandom_range(0, 7) == 0) tCfg[$urandom_range(0, NO-1)] = 24'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                int lj;
                lj = $urandom_range(0, NO-1);
                tBlank[lj] = ~tBlank[lj];
            end
            tIData = 16'($urandom);
            if ($urandom_range(0, 7) == 0)
                icmd(1, $urandom_range(0, 31), $urandom_range(0, 40), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0)
                icmd(2, $urandom_range(0, 31), $urandom_range(0, 40), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end
endmodule
